lsu_pmem_master: RTL

//  Load/store initiator driving the 32-bit DPI physical-memory port (raddr/rdata, waddr/wdata/wmask).

---
 rtl/lsu_pmem_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_pmem_master.sv
// Load/store initiator for the 32-bit physical-memory port.
// Each request takes one or two word beats: one for B/H/W and two for D.
// Misaligned requests get an error response and never touch memory.
// Every output is a register. The output-comb process computes the value each
// output takes in the next state, and the output register loads it.
//
//  state | meaning
//  IDLE  | waiting for a request, req_ready high
//  BEAT0 | first (or only) word beat on the memory port
//  BEAT1 | upper word beat, D accesses only
//  RESP  | resp_valid pulse, then back to IDLE
module lsu_pmem_master #(
    parameter logic [63:0] PMEM_BASE = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [63:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state, state_nxt;

    // captured request
    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        wen_q;
    logic        uns_q;
    logic [31:0] wdhi_q;
    logic [31:0] lo_q;

    // next values of the registered outputs
    logic        req_ready_nxt;
    logic        resp_valid_nxt;
    logic        resp_err_nxt;
    logic [63:0] resp_rdata_nxt;
    logic [63:0] mem_raddr_nxt;
    logic [63:0] mem_waddr_nxt;
    logic [31:0] mem_wdata_nxt;
    logic [7:0]  mem_wmask_nxt;

    logic        accept;
    logic        misal;
    logic [63:0] hi_word_addr;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = low[0];
            2'd2:    is_misaligned = |low[1:0];
            default: is_misaligned = |low[2:0];
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Sub-doubleword load: shift the addressed lane down, then extend it.
    function automatic logic [63:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    load_ext = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    load_ext = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    load_ext = uns ? {32'd0, sh}       : {{32{sh[31]}}, sh};
            default: load_ext = {32'd0, sh};
        endcase
    endfunction

    assign accept       = req_valid && req_ready;
    assign misal        = is_misaligned(req_size, req_addr[2:0]);
    assign hi_word_addr = {addr_q[63:2], 2'b00} + 64'd4;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misal ? RESP : BEAT0;
            BEAT0:   state_nxt = (size_q == 2'd3) ? BEAT1 : RESP;
            BEAT1:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // next output values; addresses hold unless a beat of the matching kind is issued
    always_comb begin
        req_ready_nxt  = (state_nxt == IDLE);
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = 64'd0;
        mem_raddr_nxt  = mem_raddr;
        mem_waddr_nxt  = mem_waddr;
        mem_wdata_nxt  = 32'd0;
        mem_wmask_nxt  = 8'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misal) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (req_wen) begin
                        mem_waddr_nxt = {req_addr[63:2], 2'b00};
                        mem_wdata_nxt = req_wdata[31:0] << {req_addr[1:0], 3'b000};
                        mem_wmask_nxt = {4'd0, lane_mask(req_size, req_addr[1:0])};
                    end else begin
                        mem_raddr_nxt = {req_addr[63:2], 2'b00};
                    end
                end
            end
            BEAT0: begin
                if (size_q == 2'd3) begin
                    if (wen_q) begin
                        mem_waddr_nxt = hi_word_addr;
                        mem_wdata_nxt = wdhi_q;
                        mem_wmask_nxt = 8'h0F;
                    end else begin
                        mem_raddr_nxt = hi_word_addr;
                    end
                end else begin
                    resp_valid_nxt = 1'b1;
                    if (!wen_q) resp_rdata_nxt = load_ext(mem_rdata, addr_q[1:0], size_q, uns_q);
                end
            end
            BEAT1: begin
                resp_valid_nxt = 1'b1;
                if (!wen_q) resp_rdata_nxt = {mem_rdata, lo_q};
            end
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            mem_raddr  <= PMEM_BASE;
            mem_waddr  <= PMEM_BASE;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 8'd0;
        end else begin
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            mem_raddr  <= mem_raddr_nxt;
            mem_waddr  <= mem_waddr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_wmask  <= mem_wmask_nxt;
        end
    end

    // request capture on handshake; low load word kept for the D response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 64'd0;
            size_q <= 2'd0;
            wen_q  <= 1'b0;
            uns_q  <= 1'b0;
            wdhi_q <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                size_q <= req_size;
                wen_q  <= req_wen;
                uns_q  <= req_unsigned;
                wdhi_q <= req_wdata[63:32];
            end
            if (state == BEAT0) lo_q <= mem_rdata;
        end
    end

endmodule
